mul_accumulator: RTL and testbench

//  Downstream consumer of the N-bit multiplier product P. Accumulates a frame of products
//  (signed or unsigned per mode) into a wider accumulator and returns one result per frame.

---
 rtl/mul_acc_pkg.sv | 36 +++
 rtl/mul_acc_adder.sv | 38 +++
 rtl/mul_accumulator.sv | 128 ++++++++++++
 tb/tb_mul_accumulator.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_acc_pkg.sv
// Shared types and helpers for the product accumulator: FSM state encoding,
// default count width and the product sign/zero extension function.
package mul_acc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DRAIN
   } state_e;

   localparam int DEFAULT_MAX_LEN = 16;
   localparam int CNT_W           = $clog2(DEFAULT_MAX_LEN + 1);
   localparam int EXT_MAX         = 64;

   // Widens an n-bit product to accW bits; the shift-built masks stay correct up to 64 bits.
   function automatic logic [EXT_MAX-1:0] ext_prod(
      input logic [EXT_MAX-1:0] p,
      input logic               mode,
      input int                 n,
      input int                 accW
   );
      logic [EXT_MAX-1:0] prodMask;
      logic [EXT_MAX-1:0] accMask;
      logic [EXT_MAX-1:0] result;
      logic               signBit;
      prodMask = (EXT_MAX'(1) << n) - EXT_MAX'(1);
      accMask  = (EXT_MAX'(1) << accW) - EXT_MAX'(1);
      signBit  = |(p & (EXT_MAX'(1) << (n - 1)));
      result   = p & prodMask;
      if (mode && signBit) begin
         result = result | ~prodMask;
      end
      return result & accMask;
   endfunction

endpackage

// File: rtl/mul_acc_adder.sv
// Combinational accumulate step: adds an extended product to the running sum,
// flags signed/unsigned overflow and optionally clamps the result.
module mul_acc_adder
   import mul_acc_pkg::*;
#(
   parameter int ACC_W = 20,
   parameter int SAT   = 1
) (
   input  logic [ACC_W-1:0] i_acc,
   input  logic [ACC_W-1:0] i_ext,
   input  logic             i_mode,
   output logic [ACC_W-1:0] o_sum,
   output logic             o_ovf
);

   logic [ACC_W:0]   w_raw;
   logic             w_signedOvf;
   logic             w_unsignedOvf;
   logic             w_ovf;
   logic [ACC_W-1:0] w_clamp;

   assign w_raw         = {1'b0, i_acc} + {1'b0, i_ext};
   assign w_signedOvf   = (i_acc[ACC_W-1] == i_ext[ACC_W-1]) && (w_raw[ACC_W-1] != i_acc[ACC_W-1]);
   assign w_unsignedOvf = w_raw[ACC_W];
   assign w_ovf         = i_mode ? w_signedOvf : w_unsignedOvf;

   // A signed overflow always heads in the direction of the operands' shared sign.
   always_comb begin
      w_clamp = '1;
      if (i_mode) begin
         w_clamp = i_acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
   end

   assign o_sum = (w_ovf && (SAT != 0)) ? w_clamp : w_raw[ACC_W-1:0];
   assign o_ovf = w_ovf;

endmodule

// File: rtl/mul_accumulator.sv
// Frame accumulator behind the multiplier: sums a frame of products into a wider
// register and hands one held result per frame downstream over valid/ready.
module mul_accumulator
   import mul_acc_pkg::*;
#(
   parameter int N       = 8,
   parameter int ACC_W   = 20,
   parameter int MAX_LEN = 16,
   parameter int SAT     = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [N-1:0]                   in_p,
   input  logic                           in_mode,
   input  logic                           in_last,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [ACC_W-1:0]               out_acc,
   output logic [$clog2(MAX_LEN+1)-1:0]   out_count,
   output logic                           out_mode,
   output logic                           out_ovf
);

   localparam int CntW = $clog2(MAX_LEN + 1);

   if (ACC_W <= N || ACC_W > EXT_MAX || N > EXT_MAX) begin : gWidthCheck
      $error("mul_accumulator: need N < ACC_W <= 64");
   end

   state_e           r_state;
   logic [ACC_W-1:0] r_acc;
   logic [CntW-1:0]  r_count;
   logic             r_ovf;
   logic             r_mode;
   logic             r_outValid;
   logic [ACC_W-1:0] r_outAcc;
   logic [CntW-1:0]  r_outCount;
   logic             r_outMode;
   logic             r_outOvf;

   logic             w_idle;
   logic             w_accept;
   logic             w_frameMode;
   logic [ACC_W-1:0] w_accIn;
   logic [ACC_W-1:0] w_ext;
   logic [ACC_W-1:0] w_sum;
   logic             w_addOvf;
   logic             w_ovfNext;
   logic [CntW-1:0]  w_countNext;
   logic             w_close;

   // The first beat of a frame starts from a clean slate and supplies the frame mode.
   assign w_idle      = (r_state == IDLE);
   assign in_ready    = (r_state != DRAIN);
   assign w_accept    = in_valid && in_ready;
   assign w_frameMode = w_idle ? in_mode : r_mode;
   assign w_accIn     = w_idle ? '0 : r_acc;
   assign w_ovfNext   = (w_idle ? 1'b0 : r_ovf) | w_addOvf;
   assign w_countNext = (w_idle ? '0 : r_count) + CntW'(1);
   assign w_close     = in_last || (w_countNext == CntW'(MAX_LEN));
   assign w_ext       = ACC_W'(ext_prod(EXT_MAX'(in_p), w_frameMode, N, ACC_W));

   mul_acc_adder #(
      .ACC_W (ACC_W),
      .SAT   (SAT)
   ) uAdder (
      .i_acc  (w_accIn),
      .i_ext  (w_ext),
      .i_mode (w_frameMode),
      .o_sum  (w_sum),
      .o_ovf  (w_addOvf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_acc      <= '0;
         r_count    <= '0;
         r_ovf      <= 1'b0;
         r_mode     <= 1'b0;
         r_outValid <= 1'b0;
         r_outAcc   <= '0;
         r_outCount <= '0;
         r_outMode  <= 1'b0;
         r_outOvf   <= 1'b0;
      end else begin
         case (r_state)
            IDLE, ACCUM: begin
               if (w_accept) begin
                  r_mode  <= w_frameMode;
                  r_acc   <= w_sum;
                  r_count <= w_countNext;
                  r_ovf   <= w_ovfNext;
                  if (w_close) begin
                     r_state    <= DRAIN;
                     r_outValid <= 1'b1;
                     r_outAcc   <= w_sum;
                     r_outCount <= w_countNext;
                     r_outMode  <= w_frameMode;
                     r_outOvf   <= w_ovfNext;
                  end else begin
                     r_state <= ACCUM;
                  end
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  r_state    <= IDLE;
                  r_outValid <= 1'b0;
                  r_acc      <= '0;
                  r_count    <= '0;
                  r_ovf      <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign out_valid = r_outValid;
   assign out_acc   = r_outAcc;
   assign out_count = r_outCount;
   assign out_mode  = r_outMode;
   assign out_ovf   = r_outOvf;

endmodule

// File: tb/tb_mul_accumulator.sv
// Bench for mul_accumulator: a directed vector table, hand-written frame/backpressure/reset
// sequences and random frames compared against an integer-arithmetic reference model.
module tb_mul_accumulator;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_p;
   logic       in_mode;
   logic       in_last;
   logic       out_ready;

   logic        inReady, outValid, outMode, outOvf;
   logic [19:0] outAcc;
   logic [4:0]  outCount;
   logic        sInReady, sOutValid, sOutMode, sOutOvf;
   logic [9:0]  sOutAcc;
   logic [4:0]  sOutCount;
   logic        wInReady, wOutValid, wOutMode, wOutOvf;
   logic [9:0]  wOutAcc;
   logic [4:0]  wOutCount;

   int nTests = 0;
   int nFail  = 0;

   always #5 clk = ~clk;

   mul_accumulator #(.N(8), .ACC_W(20), .MAX_LEN(16), .SAT(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady), .in_p(in_p),
      .in_mode(in_mode), .in_last(in_last), .out_valid(outValid), .out_ready(out_ready),
      .out_acc(outAcc), .out_count(outCount), .out_mode(outMode), .out_ovf(outOvf)
   );

   mul_accumulator #(.N(8), .ACC_W(10), .MAX_LEN(16), .SAT(1)) dutSat10 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sInReady), .in_p(in_p),
      .in_mode(in_mode), .in_last(in_last), .out_valid(sOutValid), .out_ready(out_ready),
      .out_acc(sOutAcc), .out_count(sOutCount), .out_mode(sOutMode), .out_ovf(sOutOvf)
   );

   mul_accumulator #(.N(8), .ACC_W(10), .MAX_LEN(16), .SAT(0)) dutWrap10 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(wInReady), .in_p(in_p),
      .in_mode(in_mode), .in_last(in_last), .out_valid(wOutValid), .out_ready(out_ready),
      .out_acc(wOutAcc), .out_count(wOutCount), .out_mode(wOutMode), .out_ovf(wOutOvf)
   );

   // Driving X into a live beat is a bench bug, not a design bug.
   always @(posedge clk) begin
      if (in_valid) begin
         assert (!$isunknown({in_p, in_mode})) else $error("[TB] illegal X on in_p/in_mode");
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct packed {
      logic [3:0][7:0] p;
      int              n;
      logic            modeFirst;
      logic            modeRest;
      logic [19:0]     expAcc;
      int              expCount;
      logic            expMode;
      logic            expOvf;
   } vec_t;

   vec_t vecs [5];

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      nTests++;
      if (actual !== expected) begin
         nFail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Presents one beat at a negedge, holds it until accepted, returns at the following negedge.
   task automatic applyStimulus(input logic [7:0] p, input logic mode, input logic last);
      int guard;
      in_valid = 1'b1;
      in_p     = p;
      in_mode  = mode;
      in_last  = last;
      guard    = 0;
      while (!inReady && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) begin
         nTests++;
         nFail++;
         $display("[TB] FAIL beatAccept: in_ready still 0 after 50 cycles, expected 1");
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic takeResult();
      int guard;
      guard = 0;
      while (!outValid && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) begin
         nTests++;
         nFail++;
         $display("[TB] FAIL resultWait: out_valid still 0 after 50 cycles, expected 1");
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   // Reference: exact integer sum with range checks derived from the overflow rules.
   function automatic void refFrame(input int accW, input bit sat, input logic mode, input int n,
                                    input logic [15:0][7:0] b, output logic [63:0] accOut,
                                    output logic ovf);
      longint span, lo, hi, s, e;
      span = longint'(1) << accW;
      lo   = mode ? -(span / 2) : 0;
      hi   = mode ? (span / 2) - 1 : span - 1;
      s    = 0;
      ovf  = 1'b0;
      for (int i = 0; i < n; i++) begin
         e = mode ? longint'($signed(b[i])) : longint'(b[i]);
         s = s + e;
         if (s > hi || s < lo) begin
            ovf = 1'b1;
            if (sat) begin
               s = (s > hi) ? hi : lo;
            end else begin
               s = s & (span - 1);
               if (mode && s > hi) s = s - span;
            end
         end
      end
      accOut = 64'(s & (span - 1));
   endfunction

   initial begin
      logic [15:0][7:0] beats;
      logic [63:0]      expAcc;
      logic             expOvf;
      logic             mode;
      int               len;
      int               n;

      rst = 1'b1; in_valid = 1'b0; in_p = 8'h00; in_mode = 1'b0; in_last = 1'b0; out_ready = 1'b0;

      vecs[0] = '{p: 32'h00302010, n: 3, modeFirst: 1'b0, modeRest: 1'b0,
                  expAcc: 20'h00060, expCount: 3, expMode: 1'b0, expOvf: 1'b0};
      vecs[1] = '{p: 32'h000580FF, n: 3, modeFirst: 1'b1, modeRest: 1'b1,
                  expAcc: 20'hFFF84, expCount: 3, expMode: 1'b1, expOvf: 1'b0};
      vecs[2] = '{p: 32'h0000FFFF, n: 2, modeFirst: 1'b0, modeRest: 1'b1,
                  expAcc: 20'h001FE, expCount: 2, expMode: 1'b0, expOvf: 1'b0};
      vecs[3] = '{p: 32'h00000080, n: 1, modeFirst: 1'b1, modeRest: 1'b1,
                  expAcc: 20'hFFF80, expCount: 1, expMode: 1'b1, expOvf: 1'b0};
      vecs[4] = '{p: 32'h80808080, n: 4, modeFirst: 1'b0, modeRest: 1'b0,
                  expAcc: 20'h00200, expCount: 4, expMode: 1'b0, expOvf: 1'b0};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      checkOutput("resetValid", outValid, 0);
      checkOutput("resetAcc", outAcc, 0);
      checkOutput("resetCount", outCount, 0);
      checkOutput("resetMode", outMode, 0);
      checkOutput("resetOvf", outOvf, 0);
      checkOutput("resetInReady", inReady, 1);

      for (int v = 0; v < 5; v++) begin
         for (int b = 0; b < vecs[v].n; b++) begin
            if (b == vecs[v].n - 1) checkOutput("vecPreLastValid", outValid, 0);
            applyStimulus(vecs[v].p[b], (b == 0) ? vecs[v].modeFirst : vecs[v].modeRest,
                          b == vecs[v].n - 1);
         end
         checkOutput("vecLatencyValid", outValid, 1);
         checkOutput("vecAcc", outAcc, vecs[v].expAcc);
         checkOutput("vecCount", outCount, vecs[v].expCount);
         checkOutput("vecMode", outMode, vecs[v].expMode);
         checkOutput("vecOvf", outOvf, vecs[v].expOvf);
         checkOutput("vecDrainInReady", inReady, 0);
         takeResult();
         checkOutput("vecPostHandshakeValid", outValid, 0);
      end

      // Sixteen signed 0x7F beats with no last: force-closed at MAX_LEN.
      for (int b = 0; b < 16; b++) applyStimulus(8'h7F, 1'b1, 1'b0);
      checkOutput("maxLenValid20", outValid, 1);
      checkOutput("maxLenAcc20", outAcc, 20'h007F0);
      checkOutput("maxLenOvf20", outOvf, 0);
      checkOutput("maxLenCount20", outCount, 16);
      checkOutput("satAcc", sOutAcc, 10'h1FF);
      checkOutput("satOvf", sOutOvf, 1);
      checkOutput("satCount", sOutCount, 16);
      checkOutput("satMode", sOutMode, 1);
      checkOutput("satInReady", sInReady, 0);
      checkOutput("wrapAcc", wOutAcc, 10'h3F0);
      checkOutput("wrapOvf", wOutOvf, 1);
      checkOutput("wrapCount", wOutCount, 16);
      checkOutput("wrapMode", wOutMode, 1);
      checkOutput("wrapInReady", wInReady, 0);
      takeResult();

      // Backpressure: result held for 5 cycles while a pending beat waits upstream.
      applyStimulus(8'h11, 1'b0, 1'b0);
      applyStimulus(8'h22, 1'b0, 1'b1);
      in_valid = 1'b1; in_p = 8'h07; in_mode = 1'b0; in_last = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checkOutput("bpInReady", inReady, 0);
         checkOutput("bpValid", outValid, 1);
         checkOutput("bpAcc", outAcc, 20'h00033);
         checkOutput("bpCount", outCount, 2);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("bpReleaseValid", outValid, 0);
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      checkOutput("bpNextValid", outValid, 1);
      checkOutput("bpNextAcc", outAcc, 20'h00007);
      checkOutput("bpNextCount", outCount, 1);
      takeResult();

      // Reset mid-frame discards the partial frame.
      applyStimulus(8'h40, 1'b0, 1'b0);
      applyStimulus(8'h40, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checkOutput("midResetValid", outValid, 0);
      end
      applyStimulus(8'h01, 1'b0, 1'b1);
      checkOutput("postResetAcc", outAcc, 20'h00001);
      checkOutput("postResetCount", outCount, 1);
      checkOutput("postResetOvf", outOvf, 0);

      // Reset while a result waits in DRAIN drops it the next cycle.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("drainResetValid", outValid, 0);
      checkOutput("drainResetAcc", outAcc, 0);
      checkOutput("drainResetInReady", inReady, 1);

      for (int f = 0; f < 40; f++) begin
         mode = 1'($urandom_range(0, 1));
         len  = $urandom_range(1, 20);
         n    = (len > 16) ? 16 : len;
         beats = '0;
         for (int b = 0; b < n; b++) begin
            beats[b] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            applyStimulus(beats[b], (b == 0) ? mode : 1'($urandom_range(0, 1)),
                          (len <= 16) && (b == n - 1));
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
         refFrame(20, 1'b1, mode, n, beats, expAcc, expOvf);
         checkOutput("rndValid20", outValid, 1);
         checkOutput("rndAcc20", outAcc, expAcc);
         checkOutput("rndOvf20", outOvf, expOvf);
         checkOutput("rndCount20", outCount, n);
         checkOutput("rndMode20", outMode, mode);
         refFrame(10, 1'b1, mode, n, beats, expAcc, expOvf);
         checkOutput("rndAccSat10", sOutAcc, expAcc);
         checkOutput("rndOvfSat10", sOutOvf, expOvf);
         checkOutput("rndCountSat10", sOutCount, n);
         refFrame(10, 1'b0, mode, n, beats, expAcc, expOvf);
         checkOutput("rndAccWrap10", wOutAcc, expAcc);
         checkOutput("rndOvfWrap10", wOutOvf, expOvf);
         checkOutput("rndModeWrap10", wOutMode, mode);
         takeResult();
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
